// File: rtl/rns_mod7_pkg.sv
// rtl/rns_mod7_pkg.sv - shared types and constants for the mod-7 thermometer accumulator
package rns_mod7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        STEP   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int          MOD7         = 7;
    localparam int          TC7_W        = MOD7 - 1;
    localparam logic [5:0]  TC7_ZERO     = 6'b000000;
    localparam logic [5:0]  TC7_MAX      = 6'b111111;
    localparam logic [2:0]  RES7_INVALID = 3'b111;

    // Binary value of a legal thermometer word is simply its count of ones.
    function automatic logic [2:0] tc7_to_bin(input logic [TC7_W-1:0] tc);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < TC7_W; i++) begin
            cnt = cnt + {2'b00, tc[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/tc_mod7_inc.sv
// rtl/tc_mod7_inc.sv - combinational thermometer +1 modulo 7
module tc_mod7_inc
    import rns_mod7_pkg::*;
(
    input  logic [TC7_W-1:0] i_tc,
    output logic [TC7_W-1:0] o_tc
);

    // Shift a one in from the bottom; the all-ones word (value 6) wraps to zero.
    always_comb begin
        o_tc = {i_tc[TC7_W-2:0], 1'b1};
        if (i_tc == TC7_MAX) begin
            o_tc = TC7_ZERO;
        end
    end

endmodule

// File: rtl/tc_mod7_accum_ctrl.sv
// rtl/tc_mod7_accum_ctrl.sv - burst accumulator mod 7 in thermometer code; optional TC7_MOD7 invalid check via TC_MOD7_INVALID_CHK_EN
module tc_mod7_accum_ctrl
    import rns_mod7_pkg::*;
#(
    parameter int LEN_W = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             op_valid,
    input  logic [2:0]       op_data,
    output logic             op_ready,
    output logic             busy,
    output logic             res_valid,
    output logic [TC7_W-1:0] res_tc,
`ifdef TC_MOD7_INVALID_CHK_EN
    output logic [2:0]       res_bin,
    output logic             err
`else
    output logic [2:0]       res_bin
`endif
);

    state_t             r_state;
    state_t             w_next_state;
    logic [TC7_W-1:0]   r_acc;
    logic [LEN_W-1:0]   r_cnt;
    logic [2:0]         r_rem;
    logic               r_res_valid;
    logic [TC7_W-1:0]   r_res_tc;
    logic [2:0]         r_res_bin;
    logic               w_op_ready;
    logic               w_busy;
    logic               w_hs;
    logic [2:0]         w_op_val;
    logic [TC7_W-1:0]   w_acc_inc;
    logic               w_last_op;

    tc_mod7_inc u_inc (
        .i_tc (r_acc),
        .o_tc (w_acc_inc)
    );

    // The invalid code carries no magnitude, so it always takes the zero-step path.
    assign w_op_val  = (op_data == RES7_INVALID) ? 3'd0 : op_data;
    assign w_hs      = w_op_ready & op_valid;
    assign w_last_op = (r_cnt == LEN_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_op_ready   = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_next_state = (len == '0) ? DONE : ACCEPT;
                end
            end
            ACCEPT: begin
                w_op_ready = 1'b1;
                if (op_valid) begin
                    if (w_op_val == 3'd0) begin
                        w_next_state = w_last_op ? DONE : ACCEPT;
                    end else begin
                        w_next_state = STEP;
                    end
                end
            end
            STEP: begin
                if (r_rem == 3'd1) begin
                    w_next_state = w_last_op ? DONE : ACCEPT;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Accumulator, operand/step counters and the registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= TC7_ZERO;
            r_cnt       <= '0;
            r_rem       <= 3'd0;
            r_res_valid <= 1'b0;
            r_res_tc    <= TC7_ZERO;
            r_res_bin   <= 3'd0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc     <= TC7_ZERO;
                        r_cnt     <= len;
                        r_res_tc  <= TC7_ZERO;
                        r_res_bin <= 3'd0;
                    end
                end
                ACCEPT: begin
                    if (w_hs) begin
                        r_rem <= w_op_val;
                        if (w_op_val == 3'd0) begin
                            r_cnt <= r_cnt - LEN_W'(1);
                        end
                    end
                end
                STEP: begin
                    r_acc <= w_acc_inc;
                    r_rem <= r_rem - 3'd1;
                    if (r_rem == 3'd1) begin
                        r_cnt <= r_cnt - LEN_W'(1);
                    end
                end
                DONE: begin
                    r_res_valid <= 1'b1;
                    r_res_tc    <= r_acc;
                    r_res_bin   <= tc7_to_bin(r_acc);
                end
                default: begin
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef TC_MOD7_INVALID_CHK_EN
    logic r_err;

    // Sticky flag for an invalid residue seen on a handshake; a new burst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_err <= 1'b0;
        end else if (w_hs && (op_data == RES7_INVALID)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

    assign op_ready  = w_op_ready;
    assign busy      = w_busy;
    assign res_valid = r_res_valid;
    assign res_tc    = r_res_tc;
    assign res_bin   = r_res_bin;

endmodule

// File: tb/tb_tc_mod7_accum_ctrl.sv
// tb/tb_tc_mod7_accum_ctrl.sv - scoreboard bench for tc_mod7_accum_ctrl
module tb_tc_mod7_accum_ctrl;

    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             op_valid;
    logic [2:0]       op_data;
    logic             op_ready;
    logic             busy;
    logic             res_valid;
    logic [5:0]       res_tc;
    logic [2:0]       res_bin;
`ifdef TC_MOD7_INVALID_CHK_EN
    logic             err;
`endif

    tc_mod7_accum_ctrl #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .op_valid  (op_valid),
        .op_data   (op_data),
        .op_ready  (op_ready),
        .busy      (busy),
        .res_valid (res_valid),
        .res_tc    (res_tc),
`ifdef TC_MOD7_INVALID_CHK_EN
        .res_bin   (res_bin),
        .err       (err)
`else
        .res_bin   (res_bin)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int tc;
        int bin;
        int lat;
        int err;
    } exp_t;

    exp_t sb[$];
    int   g_ops[$];
    int   g_gaps[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_start = 0;
    logic prev_rv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            chk("res_valid_single_pulse", int'(prev_rv), 0);
            if (sb.size() == 0) begin
                chk("unexpected_res_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_tc", int'(res_tc), e.tc);
                chk("res_bin", int'(res_bin), e.bin);
                chk("latency", cyc - last_start, e.lat);
                chk("busy_at_result", int'(busy), 0);
`ifdef TC_MOD7_INVALID_CHK_EN
                chk("err", int'(err), e.err);
`endif
            end
        end
        prev_rv <= res_valid & ~rst;
    end

    task automatic add(input int op, input int gap);
        g_ops.push_back(op);
        g_gaps.push_back(gap);
    endtask

    // Reference: residues summed with plain arithmetic; timing from per-operand cost.
    task automatic push_expect();
        exp_t e;
        int sum = 0;
        int lat = 1;
        int bad = 0;
        foreach (g_ops[i]) begin
            int v;
            v = (g_ops[i] == 7) ? 0 : g_ops[i];
            if (g_ops[i] == 7) bad = 1;
            sum += v;
            lat += 1 + v + g_gaps[i];
        end
        sum    = sum % 7;
        e.bin  = sum;
        e.tc   = (1 << sum) - 1;
        e.lat  = lat;
        e.err  = bad;
        sb.push_back(e);
    endtask

    task automatic run_burst();
        int n;
        int budget;
        n = g_ops.size();
        push_expect();
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
        len   = LEN_W'($urandom_range(0, 15));
        last_start = cyc;
        chk("busy_after_start", int'(busy), 1);
`ifdef TC_MOD7_INVALID_CHK_EN
        chk("err_cleared_by_start", int'(err), 0);
`endif
        if (n == 0) chk("op_ready_len0", int'(op_ready), 0);
        foreach (g_ops[i]) begin
            int v;
            v = (g_ops[i] == 7) ? 0 : g_ops[i];
            for (int k = 0; k < g_gaps[i]; k++) begin
                chk("op_ready_in_gap", int'(op_ready), 1);
                @(negedge clk);
            end
            op_valid = 1'b1;
            op_data  = 3'(g_ops[i]);
            chk("op_ready_at_handshake", int'(op_ready), 1);
            @(negedge clk);
            op_valid = 1'b0;
            op_data  = 3'($urandom_range(0, 7));
            for (int k = 0; k < v; k++) begin
                chk("op_ready_low_in_step", int'(op_ready), 0);
                @(negedge clk);
            end
        end
        budget = 0;
        while (sb.size() != 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0) begin
            chk("result_timeout", 0, 1);
            sb.delete();
        end
        @(negedge clk);
        g_ops.delete();
        g_gaps.delete();
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        op_valid = 1'b0;
        op_data  = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_op_ready", int'(op_ready), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_res_valid", int'(res_valid), 0);
        chk("reset_res_tc", int'(res_tc), 0);
        chk("reset_res_bin", int'(res_bin), 0);
`ifdef TC_MOD7_INVALID_CHK_EN
        chk("reset_err", int'(err), 0);
`endif
        rst = 1'b0;

        add(5, 0); add(4, 0); add(6, 0);
        run_burst();

        run_burst();

        add(6, 0); add(1, 0);
        run_burst();

        add(1, 3); add(2, 3); add(3, 3); add(0, 3);
        run_burst();

        // Reset while stepping through operand 5 of a single-operand burst.
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(1);
        @(negedge clk);
        start    = 1'b0;
        op_valid = 1'b1;
        op_data  = 3'd5;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_op_ready", int'(op_ready), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_res_valid", int'(res_valid), 0);
        chk("midrst_res_tc", int'(res_tc), 0);
        chk("midrst_res_bin", int'(res_bin), 0);
`ifdef TC_MOD7_INVALID_CHK_EN
        chk("midrst_err", int'(err), 0);
`endif
        rst = 1'b0;
        add(3, 0);
        run_burst();

        add(7, 0); add(2, 1);
        run_burst();
`ifdef TC_MOD7_INVALID_CHK_EN
        chk("err_sticky_after_burst", int'(err), 1);
`endif

        for (int b = 0; b < 25; b++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int i = 0; i < n; i++) add($urandom_range(0, 7), $urandom_range(0, 2));
            run_burst();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
